ysyx_22040175_dmem_resp: RTL and testbench

YSYX_22040175_DMEM_RESP -- requirements
Module: ysyx_22040175_dmem_resp

---
 rtl/ysyx_22040175_dmem_resp.sv | 148 ++++++++++++++
 tb/tb_ysyx_22040175_dmem_resp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040175_dmem_resp.sv
// Fixed-latency data-memory responder: one outstanding load/store, address range check, stall-safe response.
// Optional macro YSYX_22040175_DMEM_WSTRB_EN enables byte-lane write strobes; otherwise stores write full words.
//
// state | meaning
// IDLE  | ready for a request (req_ready high while rst high)
// WAIT  | latency countdown; access performed at the edge where cnt == 0
// RESP  | response presented, held until rsp_ready
module ysyx_22040175_dmem_resp #(
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2,
  parameter logic [31:0] BASE    = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  // 33-bit limit so BASE + 4*DEPTH cannot wrap past 2^32
  localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'(DEPTH) << 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [31:0]   mem [DEPTH];
  logic          addr_err;
  logic [AW-1:0] idx;
  logic          commit;
  logic          mem_we;

`ifdef YSYX_22040175_DMEM_WSTRB_EN
  logic [3:0]    wstrb_q, wstrb_d;
`else
  logic          unused_wstrb;
  assign unused_wstrb = ^req_wstrb;
`endif

  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE) || ({1'b0, addr_q} >= LIMIT);
  assign idx      = AW'((addr_q - BASE) >> 2);
  assign commit   = (state_q == WAIT) && (cnt_q == '0);
  assign mem_we   = commit && we_q && !addr_err;

  assign req_ready = rst && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef YSYX_22040175_DMEM_WSTRB_EN
    wstrb_d     = wstrb_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
`ifdef YSYX_22040175_DMEM_WSTRB_EN
          wstrb_d = req_wstrb;
`endif
          cnt_d   = CW'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (commit) begin
          rsp_err_d   = addr_err;
          rsp_rdata_d = (we_q || addr_err) ? 32'h0 : mem[idx];
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
`ifdef YSYX_22040175_DMEM_WSTRB_EN
      wstrb_q     <= 4'h0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef YSYX_22040175_DMEM_WSTRB_EN
      wstrb_q     <= wstrb_d;
`endif
    end
  end

  // Memory is deliberately not reset so contents survive rst pulses
  always_ff @(posedge clk) begin
    if (mem_we) begin
`ifdef YSYX_22040175_DMEM_WSTRB_EN
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
`else
      mem[idx] <= wdata_q;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_22040175_dmem_resp.sv
// Directed self-checking bench for ysyx_22040175_dmem_resp (DEPTH=1024, LATENCY=2).
// Expected strobe result follows YSYX_22040175_DMEM_WSTRB_EN when defined.
module tb_ysyx_22040175_dmem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wstrb = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

`ifdef YSYX_22040175_DMEM_WSTRB_EN
  localparam logic [31:0] EXP_10 = 32'hDEADAAEF;
`else
  localparam logic [31:0] EXP_10 = 32'h0000AA00;
`endif

  ysyx_22040175_dmem_resp #(
    .DEPTH(1024), .LATENCY(2), .BASE(32'h8000_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issues one request with rsp_ready high; returns data, error and edges to rsp_valid.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rd, output logic e,
                        output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!rsp_valid && lat < 20);
    rd = rsp_rdata; e = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    req_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 32'h8000_0010, 32'hDEADBEEF, 4'hF, rd, e, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL store_latency got %0d want 2", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL store_err got %b want 0", e); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL store_rdata got %h want 0", rd); end
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, e, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency got %0d want 2", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL load_err got %b want 0", e); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got %h want deadbeef", rd); end
  endtask

  task automatic test_wstrb;
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 32'h8000_0010, 32'h0000AA00, 4'b0010, rd, e, lat);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL strb_store_err got %b want 0", e); end
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, e, lat);
    checks++; if (rd !== EXP_10) begin errors++; $display("FAIL strb_load_rdata got %h want %h", rd, EXP_10); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 32'h8000_0FFC, 32'hCAFEF00D, 4'hF, rd, e, lat);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL last_word_store_err got %b want 0", e); end
    do_req(1'b1, 32'h8000_0000, 32'h55555555, 4'hF, rd, e, lat);
    do_req(1'b0, 32'h8000_0012, 32'h0, 4'h0, rd, e, lat);
    checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned got err=%b rdata=%h want err=1 rdata=0", e, rd); end
    do_req(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, rd, e, lat);
    checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL below_base got err=%b rdata=%h want err=1 rdata=0", e, rd); end
    do_req(1'b1, 32'h8000_1000, 32'h99999999, 4'hF, rd, e, lat);
    checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL above_top_store got err=%b rdata=%h want err=1 rdata=0", e, rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL error_latency got %0d want 2", lat); end
    do_req(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, rd, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL high_addr got err=%b want 1", e); end
    do_req(1'b0, 32'h8000_0FFC, 32'h0, 4'h0, rd, e, lat);
    checks++; if (e !== 1'b0 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL last_word_reload got err=%b rdata=%h want err=0 rdata=cafef00d", e, rd); end
    do_req(1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, e, lat);
    checks++; if (rd !== 32'h55555555) begin errors++; $display("FAIL word0_untouched got %h want 55555555", rd); end
  endtask

  task automatic test_backpressure;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0010; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_addr = 32'h8000_0FFC;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rsp_valid && n < 20);
    checks++; if (n !== 2) begin errors++; $display("FAIL bp_latency got %0d want 2", n); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== EXP_10 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=0 rdy=0",
                 c, rsp_valid, rsp_rdata, rsp_err, req_ready, EXP_10);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept got rdy=%b want 0", req_ready); end
    req_valid = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rsp_valid && n < 20);
    checks++; if (n !== 2 || rsp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL bp_next_rsp got lat=%0d d=%h want lat=2 d=cafef00d", n, rsp_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_rv;
    logic [7:0] exp_rr;
    exp_rv = 8'b0100_0100;
    exp_rr = 8'b1000_1000;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0FFC; rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 7) req_valid = 1'b0;
      checks++;
      if (rsp_valid !== exp_rv[c] || req_ready !== exp_rr[c]) begin
        errors++;
        $display("FAIL b2b edge %0d got v=%b rdy=%b want v=%b rdy=%b", c, rsp_valid, req_ready, exp_rv[c], exp_rr[c]);
      end
      if (exp_rv[c]) begin
        checks++;
        if (rsp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_rdata edge %0d got %h want cafef00d", c, rsp_rdata); end
      end
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 32'h8000_0020, 32'h11112222, 4'hF, rd, e, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'h12345678;
    req_wstrb = 4'hF; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs got v=%b d=%h e=%b rdy=%b want all 0", rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    do_req(1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, e, lat);
    checks++; if (rd !== 32'h11112222 || e !== 1'b0) begin errors++; $display("FAIL abort_mem got d=%h e=%b want d=11112222 e=0", rd, e); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_wstrb();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
